// File: rtl/riscv_core_pkg.sv
// Shared RV32I core enums used by the control unit, the datapath and their bench.
package riscv_core_pkg;

   typedef enum logic [3:0] {
      ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, SRC1, SRC2
   } alu_ctrl_t;

   typedef enum logic [1:0] {
      LESS, EQUAL, GREATER
   } alu_comp_t;

endpackage

// File: rtl/riscv_ctrl_fsm_if.sv
// Control-unit <-> datapath bundle: instruction/compare/memory-ack in, every select and enable out.
// master = control unit, slave = datapath side.
interface riscv_ctrl_fsm_if;

   logic [31:0]                instr;
   riscv_core_pkg::alu_comp_t  ALU_comp;
   logic                       mem_ack;

   logic [1:0]                 ALU_src1_sel;
   logic [1:0]                 ALU_src2_sel;
   riscv_core_pkg::alu_ctrl_t  ALU_ctrl;
   logic                       pc_we;
   logic                       pc_src;
   logic                       pc_clr_lsb;
   logic                       ir_we;
   logic                       alu_out_we;
   logic                       rd_we;
   logic [1:0]                 result_sel;
   logic                       mem_req;
   logic                       mem_we;
   logic                       mem_addr_sel;
   logic                       halt;

   modport master (
      input  instr, ALU_comp, mem_ack,
      output ALU_src1_sel, ALU_src2_sel, ALU_ctrl, pc_we, pc_src, pc_clr_lsb,
             ir_we, alu_out_we, rd_we, result_sel, mem_req, mem_we, mem_addr_sel, halt
   );

   modport slave (
      output instr, ALU_comp, mem_ack,
      input  ALU_src1_sel, ALU_src2_sel, ALU_ctrl, pc_we, pc_src, pc_clr_lsb,
             ir_we, alu_out_we, rd_we, result_sel, mem_req, mem_we, mem_addr_sel, halt
   );

endinterface

// File: rtl/riscv_ctrl_fsm.sv
// Multicycle RV32I sequencer: 3 cycles ALU/branch/jump, 4 store, 5 load with zero-wait memory.
// Request states hold mem_req until mem_ack; FETCH enables are gated by mem_ack combinationally.
module riscv_ctrl_fsm
   import riscv_core_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   riscv_ctrl_fsm_if.master  bus
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXEC_R, EXEC_I, EXEC_U, BRANCH, JAL, JALR, TRAP
   } state_t;

   state_t     state;
   state_t     state_nxt;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       alt;
   logic       branch_taken;
   logic       unused_instr_bits;

   assign opcode = bus.instr[6:0];
   assign funct3 = bus.instr[14:12];
   assign alt    = bus.instr[30];
   assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

   logic [1:0] src1;
   logic [1:0] src2;
   alu_ctrl_t  alu_op;
   logic       pc_we;
   logic       pc_src;
   logic       pc_clr_lsb;
   logic       ir_we;
   logic       alu_out_we;
   logic       rd_we;
   logic [1:0] result_sel;
   logic       mem_req;
   logic       mem_we;
   logic       mem_addr_sel;
   logic       halt;

   // instr[30] selects SUB only for register-register ops; shifts honour it in both forms.
   function automatic alu_ctrl_t exec_op(input logic [2:0] f3, input logic a, input logic is_r);
      alu_ctrl_t op;
      case (f3)
         3'd0:    op = (is_r && a) ? SUB : ADD;
         3'd1:    op = SLL;
         3'd2:    op = SLT;
         3'd3:    op = SLTU;
         3'd4:    op = XOR;
         3'd5:    op = a ? SRA : SRL;
         3'd6:    op = OR;
         default: op = AND;
      endcase
      return op;
   endfunction

   always_comb begin
      branch_taken = 1'b0;
      case (funct3)
         3'd0:       branch_taken = (bus.ALU_comp == EQUAL);
         3'd1:       branch_taken = (bus.ALU_comp != EQUAL);
         3'd4, 3'd6: branch_taken = (bus.ALU_comp == LESS);
         3'd5, 3'd7: branch_taken = (bus.ALU_comp != LESS);
         default:    branch_taken = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FETCH: begin
            if (bus.mem_ack) begin
               state_nxt = DECODE;
            end
         end
         DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: state_nxt = MEMADR;
               OP_R:              state_nxt = EXEC_R;
               OP_I:              state_nxt = EXEC_I;
               OP_LUI, OP_AUIPC:  state_nxt = EXEC_U;
               OP_BRANCH:         state_nxt = (funct3[2:1] == 2'b01) ? TRAP : BRANCH;
               OP_JAL:            state_nxt = JAL;
               OP_JALR:           state_nxt = JALR;
               OP_FENCE:          state_nxt = FETCH;
               default:           state_nxt = TRAP;
            endcase
         end
         // Loads and stores differ only in opcode bit 5.
         MEMADR:   state_nxt = opcode[5] ? MEMWRITE : MEMREAD;
         MEMREAD: begin
            if (bus.mem_ack) begin
               state_nxt = MEMWB;
            end
         end
         MEMWRITE: begin
            if (bus.mem_ack) begin
               state_nxt = FETCH;
            end
         end
         MEMWB, EXEC_R, EXEC_I, EXEC_U, BRANCH, JAL, JALR: state_nxt = FETCH;
         TRAP:     state_nxt = TRAP;
         default:  state_nxt = FETCH;
      endcase
   end

   // Outputs hold idle defaults throughout reset so an in-flight request drops at once.
   always_comb begin
      src1         = 2'd2;
      src2         = 2'd1;
      alu_op       = ADD;
      pc_we        = 1'b0;
      pc_src       = 1'b0;
      pc_clr_lsb   = 1'b0;
      ir_we        = 1'b0;
      alu_out_we   = 1'b0;
      rd_we        = 1'b0;
      result_sel   = 2'd0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      halt         = 1'b0;
      if (!rst) begin
         case (state)
            FETCH: begin
               mem_req = 1'b1;
               src1    = 2'd0;
               src2    = 2'd2;
               if (bus.mem_ack) begin
                  ir_we = 1'b1;
                  pc_we = 1'b1;
               end
            end
            DECODE: begin
               src1       = 2'd1;
               alu_out_we = 1'b1;
            end
            MEMADR: begin
               alu_out_we = 1'b1;
            end
            MEMREAD: begin
               mem_req      = 1'b1;
               mem_addr_sel = 1'b1;
            end
            MEMWB: begin
               rd_we      = 1'b1;
               result_sel = 2'd2;
            end
            MEMWRITE: begin
               mem_req      = 1'b1;
               mem_we       = 1'b1;
               mem_addr_sel = 1'b1;
            end
            EXEC_R: begin
               src2   = 2'd0;
               alu_op = exec_op(funct3, alt, 1'b1);
               rd_we  = 1'b1;
            end
            EXEC_I: begin
               alu_op = exec_op(funct3, alt, 1'b0);
               rd_we  = 1'b1;
            end
            EXEC_U: begin
               if (opcode == OP_LUI) begin
                  alu_op = SRC2;
               end else begin
                  src1 = 2'd1;
               end
               rd_we = 1'b1;
            end
            BRANCH: begin
               src2   = 2'd0;
               alu_op = (funct3[2:1] == 2'b11) ? SLTU : SLT;
               if (branch_taken) begin
                  pc_we  = 1'b1;
                  pc_src = 1'b1;
               end
            end
            JAL: begin
               pc_we      = 1'b1;
               pc_src     = 1'b1;
               rd_we      = 1'b1;
               result_sel = 2'd3;
            end
            // rd takes the pre-update PC on the same edge the PC is redirected.
            JALR: begin
               pc_we      = 1'b1;
               pc_clr_lsb = 1'b1;
               rd_we      = 1'b1;
               result_sel = 2'd3;
            end
            TRAP: begin
               halt = 1'b1;
            end
            default: begin
               halt = 1'b0;
            end
         endcase
      end
   end

   assign bus.ALU_src1_sel = src1;
   assign bus.ALU_src2_sel = src2;
   assign bus.ALU_ctrl     = alu_op;
   assign bus.pc_we        = pc_we;
   assign bus.pc_src       = pc_src;
   assign bus.pc_clr_lsb   = pc_clr_lsb;
   assign bus.ir_we        = ir_we;
   assign bus.alu_out_we   = alu_out_we;
   assign bus.rd_we        = rd_we;
   assign bus.result_sel   = result_sel;
   assign bus.mem_req      = mem_req;
   assign bus.mem_we       = mem_we;
   assign bus.mem_addr_sel = mem_addr_sel;
   assign bus.halt         = halt;

endmodule

// File: tb/tb_riscv_ctrl_fsm.sv
// Directed bench for riscv_ctrl_fsm: steps hand-encoded instructions and compares the whole control word each cycle.
module tb_riscv_ctrl_fsm;
   import riscv_core_pkg::*;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   riscv_ctrl_fsm_if bus();

   riscv_ctrl_fsm dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Control word: src1, src2, alu op, {pc_we,pc_src,pc_clr_lsb,ir_we,alu_out_we,rd_we},
   // result_sel, {mem_req,mem_we,mem_addr_sel,halt}.
   function automatic logic [19:0] cw(input logic [1:0] s1, input logic [1:0] s2, input alu_ctrl_t op,
                                      input logic [5:0] en, input logic [1:0] rs, input logic [3:0] m);
      return {s1, s2, op, en, rs, m};
   endfunction

   function automatic logic [19:0] obs();
      return {bus.ALU_src1_sel, bus.ALU_src2_sel, bus.ALU_ctrl,
              bus.pc_we, bus.pc_src, bus.pc_clr_lsb, bus.ir_we, bus.alu_out_we, bus.rd_we,
              bus.result_sel, bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.halt};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_cw(input string tag, input logic [19:0] exp);
      #1;
      check(tag, {12'd0, obs()}, {12'd0, exp});
   endtask

   logic [19:0] IDLE, FETCH_W, FETCH_A, DEC, MEMADR_W, MEMRD, MEMWB_W, MEMWR, TRAP_W;

   task automatic fetch_decode(input string tag, input logic [31:0] ins);
      bus.instr   = ins;
      bus.mem_ack = 1'b1;
      expect_cw({tag, "_fetch"}, FETCH_A);
      tick();
      bus.mem_ack = 1'b0;
      expect_cw({tag, "_decode"}, DEC);
      tick();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      IDLE     = cw(2'd2, 2'd1, ADD, 6'b000000, 2'd0, 4'b0000);
      FETCH_W  = cw(2'd0, 2'd2, ADD, 6'b000000, 2'd0, 4'b1000);
      FETCH_A  = cw(2'd0, 2'd2, ADD, 6'b100100, 2'd0, 4'b1000);
      DEC      = cw(2'd1, 2'd1, ADD, 6'b000010, 2'd0, 4'b0000);
      MEMADR_W = cw(2'd2, 2'd1, ADD, 6'b000010, 2'd0, 4'b0000);
      MEMRD    = cw(2'd2, 2'd1, ADD, 6'b000000, 2'd0, 4'b1010);
      MEMWB_W  = cw(2'd2, 2'd1, ADD, 6'b000001, 2'd2, 4'b0000);
      MEMWR    = cw(2'd2, 2'd1, ADD, 6'b000000, 2'd0, 4'b1110);
      TRAP_W   = cw(2'd2, 2'd1, ADD, 6'b000000, 2'd0, 4'b0001);

      rst          = 1'b1;
      bus.instr    = 32'd0;
      bus.mem_ack  = 1'b0;
      bus.ALU_comp = EQUAL;
      repeat (2) @(posedge clk);
      #1;
      expect_cw("rst_idle", IDLE);
      rst = 1'b0;
      tick();
      expect_cw("post_rst_fetch", FETCH_W);

      // add x3,x1,x2
      fetch_decode("add", 32'h002081B3);
      expect_cw("add_exec_r", cw(2'd2, 2'd0, ADD, 6'b000001, 2'd0, 4'b0000));
      tick();
      expect_cw("add_back_fetch", FETCH_W);

      // lw x5,8(x1) with three wait cycles
      fetch_decode("lw", 32'h0080A283);
      expect_cw("lw_memadr", MEMADR_W);
      tick();
      for (int i = 0; i < 3; i++) begin
         expect_cw("lw_memread_wait", MEMRD);
         tick();
      end
      bus.mem_ack = 1'b1;
      expect_cw("lw_memread_ack", MEMRD);
      tick();
      bus.mem_ack = 1'b0;
      expect_cw("lw_memwb", MEMWB_W);
      tick();
      expect_cw("lw_back_fetch", FETCH_W);

      // sw x2,4(x1) zero-wait
      fetch_decode("sw", 32'h0020A223);
      expect_cw("sw_memadr", MEMADR_W);
      tick();
      bus.mem_ack = 1'b1;
      expect_cw("sw_memwrite", MEMWR);
      tick();
      bus.mem_ack = 1'b0;
      expect_cw("sw_back_fetch", FETCH_W);

      // bne not taken / taken, bgeu taken
      fetch_decode("bne_eq", 32'h00209463);
      bus.ALU_comp = EQUAL;
      expect_cw("bne_eq_not_taken", cw(2'd2, 2'd0, SLT, 6'b000000, 2'd0, 4'b0000));
      tick();
      fetch_decode("bne_lt", 32'h00209463);
      bus.ALU_comp = LESS;
      expect_cw("bne_lt_taken", cw(2'd2, 2'd0, SLT, 6'b110000, 2'd0, 4'b0000));
      tick();
      fetch_decode("bgeu", 32'h0020F463);
      bus.ALU_comp = GREATER;
      expect_cw("bgeu_gt_taken", cw(2'd2, 2'd0, SLTU, 6'b110000, 2'd0, 4'b0000));
      tick();
      fetch_decode("bltu", 32'h0020E463);
      bus.ALU_comp = GREATER;
      expect_cw("bltu_gt_not_taken", cw(2'd2, 2'd0, SLTU, 6'b000000, 2'd0, 4'b0000));
      tick();

      // ALU op decode
      fetch_decode("srai", 32'h4030D293);
      expect_cw("srai_sra", cw(2'd2, 2'd1, SRA, 6'b000001, 2'd0, 4'b0000));
      tick();
      fetch_decode("sub", 32'h402081B3);
      expect_cw("sub_sub", cw(2'd2, 2'd0, SUB, 6'b000001, 2'd0, 4'b0000));
      tick();
      fetch_decode("addi", 32'h40000093);
      expect_cw("addi_bit30_add", cw(2'd2, 2'd1, ADD, 6'b000001, 2'd0, 4'b0000));
      tick();
      fetch_decode("lui", 32'h123452B7);
      expect_cw("lui_src2", cw(2'd2, 2'd1, SRC2, 6'b000001, 2'd0, 4'b0000));
      tick();
      fetch_decode("auipc", 32'h00000297);
      expect_cw("auipc_pcold", cw(2'd1, 2'd1, ADD, 6'b000001, 2'd0, 4'b0000));
      tick();

      // jumps and fence
      fetch_decode("jal", 32'h010000EF);
      expect_cw("jal_state", cw(2'd2, 2'd1, ADD, 6'b110001, 2'd3, 4'b0000));
      tick();
      fetch_decode("jalr", 32'h000280E7);
      expect_cw("jalr_state", cw(2'd2, 2'd1, ADD, 6'b101001, 2'd3, 4'b0000));
      tick();
      expect_cw("jalr_back_fetch", FETCH_W);
      fetch_decode("fence", 32'h0000000F);
      expect_cw("fence_back_fetch", FETCH_W);

      // ecall traps; halt sticks and ignores mem_ack
      fetch_decode("ecall", 32'h00000073);
      bus.mem_ack = 1'b1;
      for (int i = 0; i < 10; i++) begin
         expect_cw("trap_halt", TRAP_W);
         tick();
      end
      rst = 1'b1;
      expect_cw("rst_in_trap", IDLE);
      tick();
      rst         = 1'b0;
      bus.mem_ack = 1'b0;
      expect_cw("post_trap_fetch", FETCH_W);
      tick();
      expect_cw("fetch_holds_req", FETCH_W);

      // reset in the middle of a fetch; an ack during reset must not advance
      rst         = 1'b1;
      bus.mem_ack = 1'b1;
      expect_cw("rst_mid_fetch", IDLE);
      tick();
      rst         = 1'b0;
      bus.mem_ack = 1'b0;
      expect_cw("late_ack_ignored", FETCH_W);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
